// File: rtl/pre_if_stage.sv
// pre_if_stage: fetch-PC generator driving a single-outstanding sram-like instruction port,
// buffering one returned word for if_stage and discarding responses killed by a redirect.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    output logic        pf_to_fs_valid,
    output logic [64:0] pf_to_fs_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_redir_pc, r_inst, r_buf_pc;
    logic        r_redir_valid, r_cancel, r_adel;
    logic [31:0] w_tgt, w_pend_pc, w_idle_pc, w_seq_pc, w_pc_next;
    logic        w_redir, w_pend, w_valid, w_handoff, w_kill;
    logic        w_consume, w_load, w_load_adel;

    assign w_redir   = ws_ex | ws_eret | br_taken;
    assign w_tgt     = ws_ex ? EX_ENTRY : ws_eret ? cp0_epc : br_target;
    // A redirect arriving this cycle counts as pending alongside the latched one
    assign w_pend    = w_redir | r_redir_valid;
    assign w_pend_pc = w_redir ? w_tgt : r_redir_pc;
    assign w_idle_pc = w_pend ? w_pend_pc : r_pc;
    assign w_seq_pc  = w_pend ? w_pend_pc : r_pc + 32'd4;
    assign w_valid   = (r_state == HOLD) && !ws_ex && !ws_eret;
    assign w_handoff = w_valid && fs_allowin;
    assign w_kill    = r_cancel | w_redir;

    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_consume   = 1'b0;
        w_load      = 1'b0;
        w_load_adel = 1'b0;
        case (r_state)
            IDLE: begin
                w_pc_next = w_idle_pc;
                w_consume = 1'b1;
                if (w_idle_pc[1:0] != 2'b00) begin
                    w_next      = HOLD;
                    w_load_adel = 1'b1;
                end else if (!br_stall) begin
                    w_next = REQ;
                end
            end
            REQ: if (inst_sram_addr_ok) w_next = WAIT;
            WAIT: if (inst_sram_data_ok) begin
                w_next = w_kill ? IDLE : HOLD;
                w_load = !w_kill;
            end
            HOLD: if (w_handoff) begin
                w_pc_next = w_seq_pc;
                w_consume = 1'b1;
                w_next    = (!br_stall && w_seq_pc[1:0] == 2'b00) ? REQ : IDLE;
            end else if (w_pend) begin
                w_pc_next = w_pend_pc;
                w_consume = 1'b1;
                w_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_cancel      <= 1'b0;
            r_adel        <= 1'b0;
            r_inst        <= 32'd0;
            r_buf_pc      <= 32'd0;
        end else begin
            r_state       <= w_next;
            r_pc          <= w_pc_next;
            r_redir_valid <= !w_consume && w_pend;
            if (w_redir) r_redir_pc <= w_tgt;
            r_cancel      <= (r_state == REQ || (r_state == WAIT && !inst_sram_data_ok)) && w_kill;
            if (w_load || w_load_adel) begin
                r_adel   <= w_load_adel;
                r_inst   <= w_load ? inst_sram_rdata : 32'd0;
                r_buf_pc <= w_load ? r_pc : w_idle_pc;
            end
        end
    end

    assign pf_to_fs_valid  = w_valid;
    assign pf_to_fs_bus    = {r_adel, r_inst, r_buf_pc};
    assign inst_sram_req   = (r_state == REQ);
    assign inst_sram_addr  = inst_sram_req ? r_pc : 32'd0;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wdata = 32'd0;
endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: directed scenarios against a small sram slave model (rdata = ~addr),
// logging accepted requests and handed-off words for comparison with hand-computed values.
module tb_pre_if_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        fs_allowin = 1'b1, br_stall = 1'b0, br_taken = 1'b0, ws_ex = 1'b0, ws_eret = 1'b0;
    logic [31:0] br_target = 32'd0, cp0_epc = 32'd0;
    logic        pf_to_fs_valid, inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
    logic [64:0] pf_to_fs_bus;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        ao_en = 1'b1, do_en = 1'b1, pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] reqs[$];
    logic [64:0] outs[$];
    int          n_checks = 0, n_errors = 0;

    pre_if_stage dut (
        .clk(clk), .reset(reset), .fs_allowin(fs_allowin), .br_stall(br_stall),
        .br_taken(br_taken), .br_target(br_target), .ws_ex(ws_ex), .ws_eret(ws_eret),
        .cp0_epc(cp0_epc), .pf_to_fs_valid(pf_to_fs_valid), .pf_to_fs_bus(pf_to_fs_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Slave: accepts when ao_en, returns ~addr the cycle after acceptance once do_en allows
    assign inst_sram_addr_ok = inst_sram_req && ao_en;
    assign inst_sram_data_ok = pend && do_en;
    assign inst_sram_rdata   = ~paddr;
    always @(posedge clk) begin
        pend <= (inst_sram_req && inst_sram_addr_ok) || (pend && !inst_sram_data_ok);
        if (inst_sram_req && inst_sram_addr_ok) paddr <= inst_sram_addr;
    end

    always @(negedge clk) if (!reset) begin
        if (inst_sram_req && inst_sram_addr_ok) reqs.push_back(inst_sram_addr);
        if (pf_to_fs_valid && fs_allowin) outs.push_back(pf_to_fs_bus);
    end

    function automatic logic [64:0] word(input logic [31:0] pc);
        return {1'b0, ~pc, pc};
    endfunction

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 200 && outs.size() < n; i++) tick();
        check("wait_outs", 65'(outs.size() >= n), 65'd1);
    endtask

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 200 && reqs.size() < n; i++) tick();
        check("wait_reqs", 65'(reqs.size() >= n), 65'd1);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pf_to_fs_valid) break;
        end
        check("wait_valid", 65'(i < 200), 65'd1);
        tick();
    endtask

    initial begin
        tick();
        check("rst_valid", 65'(pf_to_fs_valid), 65'd0);
        check("rst_req", 65'(inst_sram_req), 65'd0);
        check("rst_addr", 65'(inst_sram_addr), 65'd0);
        check("rst_bus", pf_to_fs_bus, 65'd0);
        check("rst_size", 65'(inst_sram_size), 65'd2);
        reset = 1'b0;
        // 1: sequential fetch after reset
        wait_outs(3);
        fs_allowin = 1'b0;
        check("t1_req0", 65'(reqs[0]), 65'h0_bfc00000);
        check("t1_req1", 65'(reqs[1]), 65'h0_bfc00004);
        check("t1_req2", 65'(reqs[2]), 65'h0_bfc00008);
        check("t1_out0", outs[0], word(32'hbfc00000));
        check("t1_out1", outs[1], word(32'hbfc00004));
        check("t1_out2", outs[2], word(32'hbfc00008));
        // 4: allowin low keeps the buffered word stable
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid", 65'(pf_to_fs_valid), 65'd1);
            check("t4_bus", pf_to_fs_bus, word(32'hbfc0000c));
            check("t4_noreq", 65'(inst_sram_req), 65'd0);
            tick();
        end
        outs.delete();
        fs_allowin = 1'b1;
        tick();
        check("t4_one", 65'(outs.size()), 65'd1);
        check("t4_out", outs[0], word(32'hbfc0000c));
        @(negedge clk);
        check("t4_drop", 65'(pf_to_fs_valid), 65'd0);
        tick();
        fs_allowin = 1'b0;
        // 2: branch during WAIT kills the outstanding response
        wait_valid();
        reqs.delete();
        do_en = 1'b0;
        fs_allowin = 1'b1;
        wait_reqs(1);
        outs.delete();
        br_taken = 1'b1;
        br_target = 32'hbfc00100;
        tick();
        br_taken = 1'b0;
        do_en = 1'b1;
        wait_outs(1);
        fs_allowin = 1'b0;
        check("t2_req0", 65'(reqs[0]), 65'h0_bfc00014);
        check("t2_req1", 65'(reqs[1]), 65'h0_bfc00100);
        check("t2_out", outs[0], word(32'hbfc00100));
        // 3: exception while the request is stalled
        wait_valid();
        ao_en = 1'b0;
        fs_allowin = 1'b1;
        tick();
        reqs.delete();
        outs.delete();
        ws_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_req", 65'(inst_sram_req), 65'd1);
            check("t3_addr", 65'(inst_sram_addr), 65'h0_bfc00108);
            tick();
            ws_ex = 1'b0;
        end
        ao_en = 1'b1;
        wait_outs(1);
        check("t3_req0", 65'(reqs[0]), 65'h0_bfc00108);
        check("t3_req1", 65'(reqs[1]), 65'h0_bfc00380);
        check("t3_out", outs[0], word(32'hbfc00380));
        // 5: eret to a misaligned epc raises adel without a request
        reqs.delete();
        outs.delete();
        ws_eret = 1'b1;
        cp0_epc = 32'hbfc00012;
        fs_allowin = 1'b0;
        tick();
        ws_eret = 1'b0;
        wait_valid();
        check("t5_bus", pf_to_fs_bus, {1'b1, 32'd0, 32'hbfc00012});
        check("t5_nreq", 65'(reqs.size()), 65'd1);
        check("t5_req0", 65'(reqs[0]), 65'h0_bfc00384);
        check("t5_noreq", 65'(inst_sram_req), 65'd0);
        // ws_ex and br_taken together in HOLD: exception vector wins
        reqs.delete();
        ws_ex = 1'b1;
        br_taken = 1'b1;
        br_target = 32'hbfc00200;
        @(negedge clk);
        check("ex_kill_valid", 65'(pf_to_fs_valid), 65'd0);
        tick();
        ws_ex = 1'b0;
        br_taken = 1'b0;
        wait_reqs(1);
        check("ex_prio_req", 65'(reqs[0]), 65'h0_bfc00380);
        check("ex_prio_nout", 65'(outs.size()), 65'd0);
        fs_allowin = 1'b1;
        wait_outs(1);
        check("ex_prio_out", outs[0], word(32'hbfc00380));
        // 6: async reset mid-WAIT, then the stale response arrives
        do_en = 1'b0;
        reqs.delete();
        wait_reqs(1);
        reset = 1'b1;
        #1;
        check("t6_req", 65'(inst_sram_req), 65'd0);
        check("t6_addr", 65'(inst_sram_addr), 65'd0);
        check("t6_valid", 65'(pf_to_fs_valid), 65'd0);
        tick();
        tick();
        reqs.delete();
        outs.delete();
        reset = 1'b0;
        do_en = 1'b1;
        wait_outs(1);
        check("t6_req0", 65'(reqs[0]), 65'h0_bfc00000);
        check("t6_out", outs[0], word(32'hbfc00000));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
